// File: rtl/mem_stage_responder_if.sv
// Request/response bus between the MEM-stage requester and the memory responder.
interface mem_stage_responder_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic        ReqByte;
  logic        ReqSignExt;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespError;
  logic        Stall;

  modport master (
    output ReqValid, ReqWrite, ReqByte, ReqSignExt, ReqAddr, ReqWData,
    input  ReqReady, RespValid, RespData, RespError, Stall
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqByte, ReqSignExt, ReqAddr, ReqWData,
    output ReqReady, RespValid, RespData, RespError, Stall
  );
endinterface

// File: rtl/mem_stage_responder.sv
// Multi-cycle big-endian data memory responder for MEM-stage loads and stores.
// One request in flight; the access is performed on the edge that enters RESP.
module mem_stage_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  mem_stage_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_INIT_I = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [3:0] CNT_INIT = CNT_INIT_I[3:0];

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  // Lane 0 is the most significant byte (big-endian).
  function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] lane);
    return word[{~lane, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sext);
    logic signed [7:0] sb;
    sb = signed'(b);
    return sext ? 32'(sb) : {24'd0, b};
  endfunction

  state_t      state;
  logic [3:0]  cnt;

  logic        req_write_p0, req_byte_p0, req_sext_p0;
  logic [31:0] req_addr_p0, req_wdata_p0;

  logic        op_write, op_byte, op_sext;
  logic [31:0] op_addr, op_wdata;
  logic [IDX_W-1:0] op_idx;
  logic [1:0]  op_lane;
  logic        misaligned, accept, fire, mem_we;
  logic [31:0] rd_word, load_data;
  logic        unused_addr;

  logic [31:0] mem [DEPTH_WORDS];

  // In IDLE the live request is used directly so a zero-latency access needs no extra cycle.
  always_comb begin
    if (state == IDLE) begin
      op_write = bus.ReqWrite;
      op_byte  = bus.ReqByte;
      op_sext  = bus.ReqSignExt;
      op_addr  = bus.ReqAddr;
      op_wdata = bus.ReqWData;
    end else begin
      op_write = req_write_p0;
      op_byte  = req_byte_p0;
      op_sext  = req_sext_p0;
      op_addr  = req_addr_p0;
      op_wdata = req_wdata_p0;
    end
  end

  assign op_idx      = op_addr[IDX_W+1:2];
  assign op_lane     = op_addr[1:0];
  assign unused_addr = ^op_addr;
  assign misaligned  = ~op_byte & (op_lane != 2'b00);
  assign accept      = (state == IDLE) & bus.ReqValid;
  assign fire        = ((state == WAIT) && (cnt == 4'd0)) || (accept && (LATENCY == 0));
  assign mem_we      = fire & op_write & ~misaligned & ~Rst;
  assign rd_word     = mem[op_idx];
  assign load_data   = op_byte ? extend_byte(lane_select(rd_word, op_lane), op_sext) : rd_word;

  assign bus.ReqReady = (state == IDLE);
  assign bus.Stall    = bus.ReqValid & ~bus.ReqReady;

  // Capture the request at acceptance; later changes on the bus are ignored.
  always_ff @(posedge Clk) begin
    if (accept) begin
      req_write_p0 <= bus.ReqWrite;
      req_byte_p0  <= bus.ReqByte;
      req_sext_p0  <= bus.ReqSignExt;
      req_addr_p0  <= bus.ReqAddr;
      req_wdata_p0 <= bus.ReqWData;
    end
  end

  // Store commit on the response edge; a byte store touches only its lane.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      if (op_byte) mem[op_idx][{~op_lane, 3'b000} +: 8] <= op_wdata[7:0];
      else         mem[op_idx] <= op_wdata;
    end
  end

  // Control FSM with registered one-cycle response outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.RespValid <= 1'b0;
      bus.RespData  <= 32'd0;
      bus.RespError <= 1'b0;
    end else begin
      bus.RespValid <= fire;
      bus.RespError <= fire & misaligned;
      bus.RespData  <= (fire & ~op_write & ~misaligned) ? load_data : 32'd0;
      unique case (state)
        IDLE: begin
          if (bus.ReqValid) begin
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_responder.sv
// Bench for mem_stage_responder: one LATENCY=2 and one LATENCY=0 instance.
module tb_mem_stage_responder;
  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_sext = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_responder_if if0();
  mem_stage_responder_if if1();

  assign if0.ReqValid   = req_valid & ~sel;
  assign if0.ReqWrite   = req_write;
  assign if0.ReqByte    = req_byte;
  assign if0.ReqSignExt = req_sext;
  assign if0.ReqAddr    = req_addr;
  assign if0.ReqWData   = req_wdata;
  assign if1.ReqValid   = req_valid & sel;
  assign if1.ReqWrite   = req_write;
  assign if1.ReqByte    = req_byte;
  assign if1.ReqSignExt = req_sext;
  assign if1.ReqAddr    = req_addr;
  assign if1.ReqWData   = req_wdata;

  mem_stage_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (.Clk(clk), .Rst(rst), .bus(if0));
  mem_stage_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut1 (.Clk(clk), .Rst(rst), .bus(if1));

  function automatic logic cur_ready();
    return sel ? if1.ReqReady : if0.ReqReady;
  endfunction
  function automatic logic cur_rvalid();
    return sel ? if1.RespValid : if0.RespValid;
  endfunction
  function automatic logic [31:0] cur_rdata();
    return sel ? if1.RespData : if0.RespData;
  endfunction
  function automatic logic cur_rerr();
    return sel ? if1.RespError : if0.RespError;
  endfunction

  // Drives one request, returns the response, the edge count from accept to RespValid,
  // the accept cycle and RespValid one cycle after the response.
  task automatic issue(input logic w, input logic b, input logic s, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] d, output logic e,
                       output int lat, output int acc_cyc, output logic after_valid);
    int n;
    @(negedge clk);
    req_write = w; req_byte = b; req_sext = s; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!cur_ready() && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    req_write = ~w; req_addr = 32'hFFFF_FFFC; req_wdata = ~wd;
    lat = -1;
    d = 32'hX;
    e = 1'bX;
    for (int i = 0; i < 40; i++) begin
      if (cur_rvalid()) begin
        lat = i;
        d = cur_rdata();
        e = cur_rerr();
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    after_valid = cur_rvalid();
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic test_reset;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0;
    #1;
    checks++; if (if0.RespValid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", if0.RespValid); end
    checks++; if (if0.RespData !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", if0.RespData); end
    checks++; if (if0.RespError !== 1'b0) begin errors++; $display("FAIL reset_rerr got %b want 0", if0.RespError); end
    checks++; if (if0.ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", if0.ReqReady); end
    checks++; if (if0.Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", if0.Stall); end
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load(input logic s, input int want_lat, input int min_gap);
    logic [31:0] d; logic e, av; int lat, c0, c1;
    exp_t x;
    sel = s;
    push_exp(32'd0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, d, e, lat, c0, av);
    x = exp_q.pop_front();
    checks++; if (lat !== want_lat) begin errors++; $display("FAIL sw_latency sel=%0d got %0d want %0d", s, lat, want_lat); end
    checks++; if (d !== x.data || e !== x.err) begin errors++; $display("FAIL sw_resp sel=%0d got %h/%b want %h/%b", s, d, e, x.data, x.err); end
    checks++; if (av !== 1'b0) begin errors++; $display("FAIL resp_pulse sel=%0d got %b want 0", s, av); end
    push_exp(32'hDEADBEEF, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, d, e, lat, c1, av);
    x = exp_q.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin errors++; $display("FAIL lw_resp sel=%0d got %h/%b want %h/%b", s, d, e, x.data, x.err); end
    checks++; if (c1 - c0 < min_gap) begin errors++; $display("FAIL accept_gap sel=%0d got %0d want >=%0d", s, c1 - c0, min_gap); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] d; logic e, av; int lat, c;
    logic [31:0] addrs [5] = '{32'h20, 32'h20, 32'h21, 32'h22, 32'h23};
    logic        sexts [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] wants [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF, 32'h00000001, 32'h0000007F};
    exp_t x;
    sel = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 32'h20, 32'h80FF017F, d, e, lat, c, av);
    for (int i = 0; i < 5; i++) begin
      push_exp(wants[i], 1'b0);
      issue(1'b0, 1'b1, sexts[i], addrs[i], 32'h0, d, e, lat, c, av);
      x = exp_q.pop_front();
      checks++;
      if (d !== x.data || e !== x.err)
        begin errors++; $display("FAIL byte_load[%0d] got %h/%b want %h/%b", i, d, e, x.data, x.err); end
    end
  endtask

  task automatic test_byte_store;
    logic [31:0] d; logic e, av; int lat, c;
    exp_t x;
    sel = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 32'h20, 32'h11223344, d, e, lat, c, av);
    issue(1'b1, 1'b1, 1'b0, 32'h22, 32'hFFFFFFAA, d, e, lat, c, av);
    push_exp(32'h1122AA44, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, d, e, lat, c, av);
    x = exp_q.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin errors++; $display("FAIL byte_store got %h/%b want %h/%b", d, e, x.data, x.err); end
  endtask

  task automatic test_misaligned;
    logic [31:0] d; logic e, av; int lat, c;
    exp_t x;
    sel = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 32'h30, 32'h12345678, d, e, lat, c, av);
    push_exp(32'd0, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 32'h31, 32'hCAFEF00D, d, e, lat, c, av);
    x = exp_q.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin errors++; $display("FAIL mis_sw got %h/%b want %h/%b", d, e, x.data, x.err); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_latency got %0d want 2", lat); end
    push_exp(32'h12345678, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 32'h30, 32'h0, d, e, lat, c, av);
    x = exp_q.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin errors++; $display("FAIL mis_unchanged got %h/%b want %h/%b", d, e, x.data, x.err); end
    push_exp(32'd0, 1'b1);
    issue(1'b0, 1'b0, 1'b0, 32'h32, 32'h0, d, e, lat, c, av);
    x = exp_q.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin errors++; $display("FAIL mis_lw got %h/%b want %h/%b", d, e, x.data, x.err); end
    push_exp(32'h00000034, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 32'h31, 32'h0, d, e, lat, c, av);
    x = exp_q.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin errors++; $display("FAIL lbu_odd got %h/%b want %h/%b", d, e, x.data, x.err); end
  endtask

  task automatic test_wrap_stall;
    logic [31:0] d; logic e, av; int lat, c;
    logic stall_want [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_t x;
    sel = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 32'h1000, 32'h5, d, e, lat, c, av);
    push_exp(32'h5, 1'b0);
    @(negedge clk);
    req_write = 1'b0; req_byte = 1'b0; req_sext = 1'b0; req_addr = 32'h0; req_valid = 1'b1;
    #1;
    checks++; if (if0.Stall !== 1'b0) begin errors++; $display("FAIL stall_idle got %b want 0", if0.Stall); end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (if0.Stall !== stall_want[i]) begin errors++; $display("FAIL stall[%0d] got %b want %b", i, if0.Stall, stall_want[i]); end
      if (i == 2) begin
        x = exp_q.pop_front();
        checks++;
        if (if0.RespValid !== 1'b1 || if0.RespData !== x.data || if0.RespError !== x.err)
          begin errors++; $display("FAIL wrap_load got %b/%h/%b want 1/%h/%b", if0.RespValid, if0.RespData, if0.RespError, x.data, x.err); end
      end
      if (i < 3) @(posedge clk);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop;
    logic [31:0] d; logic e, av; int lat, c, pulses;
    exp_t x;
    sel = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 32'h40, 32'h1, d, e, lat, c, av);
    @(negedge clk);
    req_write = 1'b1; req_byte = 1'b0; req_addr = 32'h40; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++; if (if0.ReqReady !== 1'b0) begin errors++; $display("FAIL midop_busy got %b want 0", if0.ReqReady); end
    rst = 1'b1;
    #1;
    checks++; if (if0.ReqReady !== 1'b1) begin errors++; $display("FAIL midop_ready got %b want 1", if0.ReqReady); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (if0.RespValid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midop_pulses got %0d want 0", pulses); end
    push_exp(32'h1, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, d, e, lat, c, av);
    x = exp_q.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin errors++; $display("FAIL midop_mem got %h/%b want %h/%b", d, e, x.data, x.err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load(1'b0, 2, 4);
    test_byte_lanes();
    test_byte_store();
    test_misaligned();
    test_wrap_stall();
    test_reset_midop();
    test_store_load(1'b1, 0, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
